// File: rtl/alu_exec.sv
// alu_exec: multi-cycle integer execute unit placed after the operand-B mux.
// Single-cycle logic/arith/compare ops, bit-serial shifts (1 bit/cycle),
// optional bit-serial MUL enabled by defining RV_ALU_MUL_EN.
// One op in flight; valid/ready on both sides; all outputs registered.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef RV_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

  state_t          r_state;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_work;     // shift register / multiplicand
  logic [5:0]      r_cnt;      // remaining iterations
  logic [XLEN-1:0] r_result;
  logic            r_illegal;
`ifdef RV_ALU_MUL_EN
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] w_acc_nxt;
`endif

  logic [XLEN-1:0] w_quick;
  logic [XLEN-1:0] w_shift_nxt;
  logic            w_illegal;
  logic            w_is_shift;
  logic [4:0]      w_shamt;

  // Decode the incoming op and compute every single-cycle result
  always_comb begin
    w_shamt    = b[4:0];
    w_quick    = '0;
    w_illegal  = 1'b0;
    w_is_shift = 1'b0;
    case (op)
      OP_ADD:  w_quick = a + b;
      OP_SUB:  w_quick = a - b;
      OP_AND:  w_quick = a & b;
      OP_OR:   w_quick = a | b;
      OP_XOR:  w_quick = a ^ b;
      OP_SLT:  w_quick = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: w_quick = {{(XLEN-1){1'b0}}, a < b};
      // zero shift amount finishes immediately with a unchanged
      OP_SLL, OP_SRL, OP_SRA: begin
        w_is_shift = 1'b1;
        w_quick    = a;
      end
`ifdef RV_ALU_MUL_EN
      OP_MUL:  w_quick = '0;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // One-bit shift step selected by the captured op
  always_comb begin
    case (r_op)
      OP_SLL:  w_shift_nxt = {r_work[XLEN-2:0], 1'b0};
      OP_SRL:  w_shift_nxt = {1'b0, r_work[XLEN-1:1]};
      default: w_shift_nxt = {r_work[XLEN-1], r_work[XLEN-1:1]};
    endcase
  end

`ifdef RV_ALU_MUL_EN
  // Shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_work) : r_acc;
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_work    <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_illegal <= 1'b0;
`ifdef RV_ALU_MUL_EN
      r_acc     <= '0;
      r_mplier  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op      <= op;
            r_illegal <= w_illegal;
            if (w_is_shift && (w_shamt != 5'd0)) begin
              r_work  <= a;
              r_cnt   <= {1'b0, w_shamt};
              r_state <= S_SHIFT;
            end
`ifdef RV_ALU_MUL_EN
            else if (op == OP_MUL) begin
              r_work   <= a;
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= 6'd32;
              r_state  <= S_MUL;
            end
`endif
            else begin
              r_result <= w_quick;
              r_state  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_shift_nxt;
          r_cnt  <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_result <= w_shift_nxt;
            r_state  <= S_DONE;
          end
        end
`ifdef RV_ALU_MUL_EN
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_work   <= {r_work[XLEN-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          r_cnt    <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_result <= w_acc_nxt;
            r_state  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec. Stimulus pushes expected
// responses (value, illegal flag, latency) computed by a plain-arithmetic
// model; an independent monitor pops and checks on every new out_valid and
// checks that held outputs stay stable while the consumer stalls.
// Honours RV_ALU_MUL_EN the same way as the design.
module tb_alu_exec;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_exec #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy_mode = 0;  // 0 random, 1 stall, 2 always ready

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: result from the ISA definition, latency from the op class
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input int acc);
    exp_t e;
    int   sh;
    sh    = int'(y[4:0]);
    e.res = 32'd0;
    e.ill = 1'b0;
    e.lat = 1;
    e.acc = acc;
    case (o)
      4'd0: e.res = x + y;
      4'd1: e.res = x - y;
      4'd2: e.res = x & y;
      4'd3: e.res = x | y;
      4'd4: e.res = x ^ y;
      4'd5: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: e.res = (x < y) ? 32'd1 : 32'd0;
      4'd7: begin e.res = x << sh; e.lat = sh + 1; end
      4'd8: begin e.res = x >> sh; e.lat = sh + 1; end
      4'd9: begin e.res = 32'($signed(x) >>> sh); e.lat = sh + 1; end
`ifdef RV_ALU_MUL_EN
      4'd10: begin e.res = x * y; e.lat = 33; end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Present an op (caller is at a negedge); returns once acceptance is certain
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int i;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (i = 0; i < 100; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (!in_ready) begin
      flag_fail("accept_timeout");
      in_valid = 1'b0;
    end else begin
      expq.push_back(model(o, x, y, cyc));
    end
  endtask

  // Wait for the unit to return to idle, throwing junk at the inputs meanwhile
  task automatic settle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) break;
      in_valid = 1'($urandom);
      op = 4'($urandom); a = $urandom; b = $urandom;
    end
    in_valid = 1'b0;
    if (!in_ready) flag_fail("idle_timeout");
  endtask

  // Monitor / consumer
  initial begin
    exp_t        cur;
    logic [31:0] h_res;
    logic        h_ill, h_z;
    bit          seen;
    seen = 0; h_res = 0; h_ill = 0; h_z = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
        out_ready = 1'b0;
      end else begin
        if (out_valid) begin
          if (!seen) begin
            if (expq.size() == 0) flag_fail("unexpected_out_valid");
            else begin
              cur = expq.pop_front();
              chk("result", result, cur.res);
              chk("zero", {31'd0, zero}, {31'd0, cur.res == 32'd0});
              chk("illegal", {31'd0, illegal}, {31'd0, cur.ill});
              chk("latency", cyc - cur.acc, cur.lat);
            end
            h_res = result; h_ill = illegal; h_z = zero;
            seen = 1;
          end else begin
            chk("hold_result", result, h_res);
            chk("hold_illegal", {31'd0, illegal}, {31'd0, h_ill});
            chk("hold_zero", {31'd0, zero}, {31'd0, h_z});
          end
        end
        case (rdy_mode)
          1: out_ready = 1'b0;
          2: out_ready = 1'b1;
          default: out_ready = 1'($urandom);
        endcase
        if (out_valid && out_ready) seen = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] rx, ry;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed basics
    issue(4'd0, 32'h7FFFFFFF, 32'h00000001); settle();
    issue(4'd1, 32'd5, 32'd5);               settle();
    issue(4'd5, 32'hFFFFFFFF, 32'd1);        settle();
    issue(4'd6, 32'hFFFFFFFF, 32'd1);        settle();
    issue(4'd9, 32'h80000000, 32'hFFFFFFFF); settle();
    issue(4'd7, 32'd1, 32'd0);               settle();
    issue(4'd8, 32'h80000001, 32'd1);        settle();
    issue(4'd7, 32'h00000003, 32'd31);       settle();

    // Consumer stall with garbage on the input side
    rdy_mode = 1;
    issue(4'd0, 32'd100, 32'd23);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'($urandom); a = $urandom; b = $urandom;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    rdy_mode = 2;
    @(negedge clk);
    chk("release_in_ready_same", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("release_in_ready_next", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    rdy_mode = 0;

    // Reset in the middle of a shift
    issue(4'd8, 32'hF0000000, 32'd16);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd1);
    chk("midrst_illegal", {31'd0, illegal}, 32'd0);
    expq.delete();
    rst = 1'b0;
    issue(4'd0, 32'd2, 32'd3); settle();

    // MUL (build dependent) and unsupported ops
    issue(4'd10, 32'hFFFFFFFF, 32'd3); settle();
    issue(4'd15, 32'h12345678, 32'd9); settle();
    issue(4'd11, 32'd0, 32'd0);        settle();

    // Randomized traffic, back-to-back where the unit allows
    repeat (200) begin
      ro = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: rx = 32'h80000000;
        1: rx = 32'hFFFFFFFF;
        default: rx = $urandom;
      endcase
      ry = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      issue(ro, rx, ry);
      settle();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
